// File: rtl/hermes_switch_ctrl.sv
// Switch controller for one five-port Hermes router: round-robin arbitration over
// input buffers holding a header flit, XY routing, and crossbar connection tables.
module hermes_switch_ctrl #(
   parameter logic [7:0] ROUTER_ADDR = 8'h00,
   parameter int         FLIT_W      = 16
) (
   input  logic                clock,
   input  logic                reset,
   input  logic [4:0]          h,
   input  logic [5*FLIT_W-1:0] header,
   input  logic [4:0]          pkt_release,  // "release" is a reserved word in SystemVerilog
   output logic [4:0]          ack_h,
   output logic [4:0]          out_busy,
   output logic [14:0]         mux_out,
   output logic [4:0]          in_busy,
   output logic [14:0]         mux_in
);

   localparam int         N_PORTS = 5;
   localparam logic [2:0] EAST    = 3'd0;
   localparam logic [2:0] WEST    = 3'd1;
   localparam logic [2:0] NORTH   = 3'd2;
   localparam logic [2:0] SOUTH   = 3'd3;
   localparam logic [2:0] LOCAL   = 3'd4;

   typedef enum logic [1:0] {S_IDLE, S_ARB, S_ROUTE, S_GRANT} state_t;

   state_t     state, state_next;
   logic [2:0] last, sel, dst;
   logic [7:0] req_free;
   logic       arb_found;
   logic [2:0] arb_idx;
   logic [3:0] cand;
   logic [7:0] sel_addr;
   logic [2:0] route_dst;
   logic [4:0] in_clr, out_clr, in_set, out_set;

   assign req_free = {3'b000, h & ~in_busy};

   // Round-robin scan starting one past the previous winner.
   always_comb begin
      // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
      arb_found = 1'b0;
      arb_idx   = EAST;
      cand      = '0;
      for (int k = 1; k <= N_PORTS; k++) begin
         cand = {1'b0, last} + 4'(k);
         if (cand >= 4'(N_PORTS)) cand = cand - 4'(N_PORTS);
         if (!arb_found && req_free[cand[2:0]]) begin
            arb_found = 1'b1;
            arb_idx   = cand[2:0];
         end
      end
   end

   // XY routing: resolve X first, then Y, otherwise deliver locally.
   always_comb begin
      sel_addr = '0;
      for (int i = 0; i < N_PORTS; i++)
         if (sel == 3'(i)) sel_addr = header[FLIT_W*i +: 8];
      if (sel_addr[7:4] > ROUTER_ADDR[7:4])      route_dst = EAST;
      else if (sel_addr[7:4] < ROUTER_ADDR[7:4]) route_dst = WEST;
      else if (sel_addr[3:0] > ROUTER_ADDR[3:0]) route_dst = NORTH;
      else if (sel_addr[3:0] < ROUTER_ADDR[3:0]) route_dst = SOUTH;
      else                                       route_dst = LOCAL;
   end

   always_comb begin
      in_clr  = pkt_release & in_busy;
      out_clr = '0;
      for (int i = 0; i < N_PORTS; i++)
         for (int j = 0; j < N_PORTS; j++)
            if (in_clr[i] && mux_in[3*i +: 3] == 3'(j)) out_clr[j] = 1'b1;
      in_set  = (state == S_GRANT) ? (5'b00001 << sel) : 5'b00000;
      out_set = (state == S_GRANT) ? (5'b00001 << dst) : 5'b00000;
   end

   always_ff @(posedge clock) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (!reset) state <= S_IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         S_IDLE:  if (|req_free) state_next = S_ARB;
         S_ARB:   state_next = arb_found ? S_ROUTE : S_IDLE;
         S_ROUTE: state_next = out_busy[route_dst] ? S_IDLE : S_GRANT;
         S_GRANT: state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   always_comb begin
      ack_h = '0;
      if (state == S_GRANT) ack_h = 5'b00001 << sel;
   end

   // Release and grant never touch the same input or output in one cycle.
   always_ff @(posedge clock) begin
      if (!reset) begin
         last     <= LOCAL;
         sel      <= EAST;
         dst      <= EAST;
         in_busy  <= '0;
         out_busy <= '0;
         mux_out  <= '0;
         mux_in   <= '0;
      end else begin
         in_busy  <= (in_busy & ~in_clr) | in_set;
         out_busy <= (out_busy & ~out_clr) | out_set;
         if (state == S_ARB && arb_found) begin
            last <= arb_idx;
            sel  <= arb_idx;
         end
         if (state == S_ROUTE) dst <= route_dst;
         if (state == S_GRANT) begin
            for (int j = 0; j < N_PORTS; j++) begin
               if (dst == 3'(j)) mux_out[3*j +: 3] <= sel;
               if (sel == 3'(j)) mux_in[3*j +: 3]  <= dst;
            end
         end
      end
   end

endmodule

// File: tb/tb_hermes_switch_ctrl.sv
// Bench for hermes_switch_ctrl: directed scenarios with literal expectations plus a
// transaction-level reference model compared against the outputs every cycle.
module tb_hermes_switch_ctrl;

   localparam logic [7:0] ADDR = 8'h11;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic [4:0]  h     = '0;
   logic [4:0]  rel   = '0;
   logic [79:0] header = '0;
   logic [4:0]  ack_h, out_busy, in_busy;
   logic [14:0] mux_out, mux_in;

   int n_cmp = 0;
   int n_bad = 0;
   bit cmp_en = 1'b0;

   hermes_switch_ctrl #(.ROUTER_ADDR(ADDR), .FLIT_W(16)) dut (
      .clock(clock), .reset(reset), .h(h), .header(header), .pkt_release(rel),
      .ack_h(ack_h), .out_busy(out_busy), .mux_out(mux_out),
      .in_busy(in_busy), .mux_in(mux_in)
   );

   always #5 clock = ~clock;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
      end
   endtask

   // Reference model: a grant takes three cycles from the idle sample (pick, route, grant).
   function automatic int xy_route(input logic [15:0] hdr);
      int tx, ty, lx, ly;
      tx = int'(hdr[7:4]); ty = int'(hdr[3:0]);
      lx = int'(ADDR) / 16; ly = int'(ADDR) % 16;
      if (tx > lx) return 0;
      if (tx < lx) return 1;
      if (ty > ly) return 2;
      if (ty < ly) return 3;
      return 4;
   endfunction

   int       m_phase, m_last, m_sel, m_dst;
   bit [4:0] m_in_busy, m_out_busy;
   int       m_mux_out[5];
   int       m_mux_in[5];

   always @(posedge clock) begin : model
      bit [4:0] elig, old_in, old_out;
      int w, c;
      if (!reset) begin
         m_phase = 0; m_last = 4; m_sel = 0; m_dst = 0;
         m_in_busy = '0; m_out_busy = '0;
         for (int i = 0; i < 5; i++) begin m_mux_out[i] = 0; m_mux_in[i] = 0; end
      end else begin
         old_in  = m_in_busy;
         old_out = m_out_busy;
         elig    = h & ~old_in;
         for (int i = 0; i < 5; i++)
            if (rel[i] && old_in[i]) begin
               m_in_busy[i] = 1'b0;
               m_out_busy[m_mux_in[i]] = 1'b0;
            end
         case (m_phase)
            0: if (elig != 0) m_phase = 1;
            1: begin
               w = -1;
               for (int k = 1; k <= 5; k++) begin
                  c = (m_last + k) % 5;
                  if (w < 0 && elig[c]) w = c;
               end
               if (w >= 0) begin m_sel = w; m_last = w; m_phase = 2; end
               else m_phase = 0;
            end
            2: begin
               m_dst   = xy_route(header[16*m_sel +: 16]);
               m_phase = old_out[m_dst] ? 0 : 3;
            end
            default: begin
               m_out_busy[m_dst] = 1'b1;
               m_in_busy[m_sel]  = 1'b1;
               m_mux_out[m_dst]  = m_sel;
               m_mux_in[m_sel]   = m_dst;
               m_phase = 0;
            end
         endcase
      end
   end

   always @(negedge clock) begin : compare
      logic [4:0]  e_ack;
      logic [14:0] e_mo, e_mi;
      if (cmp_en) begin
         e_ack = (m_phase == 3) ? (5'b00001 << m_sel) : 5'b00000;
         for (int i = 0; i < 5; i++) begin
            e_mo[3*i +: 3] = 3'(m_mux_out[i]);
            e_mi[3*i +: 3] = 3'(m_mux_in[i]);
         end
         check("model_ack_h", ack_h, e_ack);
         check("model_out_busy", out_busy, m_out_busy);
         check("model_in_busy", in_busy, m_in_busy);
         check("model_mux_out", mux_out, e_mo);
         check("model_mux_in", mux_in, e_mi);
      end
   end

   task automatic step(input int n);
      repeat (n) begin @(posedge clock); #1; end
   endtask

   task automatic do_reset();
      reset = 1'b0; h = '0; rel = '0;
      step(2);
      reset = 1'b1;
   endtask

   task automatic set_hdr(input int i, input logic [15:0] v);
      header[16*i +: 16] = v;
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   initial begin : stim
      bit       seen, found;
      int       lat;
      int       exp_order[6];
      logic [4:0] won;

      // Single request from LOCAL to NORTH, then a stray release on an idle input.
      do_reset();
      cmp_en = 1'b1;
      check("t0_reset_out_busy", out_busy, 5'b00000);
      check("t0_reset_ack", ack_h, 5'b00000);
      set_hdr(4, 16'h0012);
      h = 5'b10000;
      step(2);
      check("t1_no_ack_c2", ack_h, 5'b00000);
      step(1);
      check("t1_ack_c3", ack_h, 5'b10000);
      h = '0;
      step(1);
      check("t1_out_busy", out_busy, 5'b00100);
      check("t1_in_busy", in_busy, 5'b10000);
      check("t1_mux_out_north", mux_out[8:6], 3'd4);
      check("t1_mux_in_local", mux_in[14:12], 3'd2);
      rel = 5'b01000;
      step(1);
      rel = '0;
      step(1);
      check("t6_out_busy_kept", out_busy, 5'b00100);
      check("t6_in_busy_kept", in_busy, 5'b10000);

      // Two simultaneous requests: EAST first, WEST four cycles later.
      do_reset();
      set_hdr(0, 16'h0021);
      set_hdr(1, 16'h0001);
      h = 5'b00011;
      step(3);
      check("t2_ack_east_c3", ack_h, 5'b00001);
      h[0] = 1'b0;
      step(4);
      check("t2_ack_west_c7", ack_h, 5'b00010);
      h[1] = 1'b0;
      step(1);
      check("t2_out_busy", out_busy, 5'b00011);
      check("t2_mux_out_west", mux_out[5:3], 3'd1);

      // Contention for LOCAL: loser waits until the winner releases.
      do_reset();
      set_hdr(2, 16'h0011);
      set_hdr(3, 16'h0011);
      h = 5'b01100;
      step(3);
      check("t3_winner_ack", ack_h, 5'b00100);
      h[2] = 1'b0;
      seen = 1'b0;
      repeat (12) begin step(1); if (ack_h != 0) seen = 1'b1; end
      check("t3_loser_held", seen, 1'b0);
      rel = 5'b00100;
      step(1);
      rel = '0;
      check("t3_local_freed", out_busy[4], 1'b0);
      found = 1'b0; lat = 0;
      for (int k = 0; k < 8 && !found; k++) begin
         if (ack_h != 0) begin found = 1'b1; lat = k; won = ack_h; end
         else step(1);
      end
      check("t3_loser_granted", found, 1'b1);
      check("t3_loser_within5", (found && lat <= 5), 1'b1);
      if (found) check("t3_loser_ack", won, 5'b01000);
      h = '0;
      step(1);

      // Fairness across EAST, NORTH and LOCAL inputs with immediate release.
      do_reset();
      set_hdr(0, 16'h0021);
      set_hdr(2, 16'h0012);
      set_hdr(4, 16'h0010);
      h = 5'b10101;
      exp_order = '{0, 2, 4, 0, 2, 4};
      for (int g = 0; g < 6; g++) begin
         found = 1'b0;
         for (int k = 0; k < 10 && !found; k++) begin
            if (ack_h != 0) found = 1'b1;
            else step(1);
         end
         check("t4_grant_seen", found, 1'b1);
         if (found) begin
            won = ack_h;
            check("t4_grant_order", won, 5'b00001 << exp_order[g]);
            step(1);
            rel = won;
            step(1);
            rel = '0;
         end
      end
      h = '0;
      step(4);

      // Reset during the grant cycle drops everything.
      do_reset();
      set_hdr(4, 16'h0012);
      h = 5'b10000;
      step(3);
      check("t5_grant_cycle", ack_h, 5'b10000);
      reset = 1'b0;
      h = '0;
      step(1);
      check("t5_ack_clear", ack_h, 5'b00000);
      check("t5_out_busy_clear", out_busy, 5'b00000);
      check("t5_in_busy_clear", in_busy, 5'b00000);
      check("t5_mux_out_clear", mux_out, 15'd0);
      check("t5_mux_in_clear", mux_in, 15'd0);
      reset = 1'b1;
      seen = 1'b0;
      repeat (8) begin step(1); if (ack_h != 0) seen = 1'b1; end
      check("t5_no_late_ack", seen, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
